// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
// Owns the PC and issues word fetches to instruction memory under a credit
// limit. Responses come back in order and are tagged with their PC through a
// small tag FIFO. They are buffered and handed to decode over a valid/ready
// handshake. A branch redirect flushes the buffer and marks every request
// still in flight as "to be dropped" when its response returns.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  // Buffer and tag FIFO share the same depth. The credit rule bounds
  // inflight + drop and occupancy by MAX_OUTSTANDING, so neither can overflow.
  localparam int DEPTH    = MAX_OUTSTANDING;
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W    = 3;  // holds 0..4
  localparam int CREDIT_W = 5;  // sum of three CNT_W counters
  localparam logic [PTR_W-1:0]    LAST_IDX     = PTR_W'(DEPTH - 1);
  localparam logic [CREDIT_W-1:0] CREDIT_LIMIT = CREDIT_W'(MAX_OUTSTANDING);

  // Circular pointer advance that also works when DEPTH is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // Architectural state.
  logic [31:0]      pc_reg,          pc_next;
  logic [CNT_W-1:0] inflight_reg,    inflight_next;
  logic [CNT_W-1:0] drop_reg,        drop_next;
  logic [CNT_W-1:0] occ_reg,         occ_next;
  logic             fault_reg,       fault_next;
  logic [PTR_W-1:0] tag_wr_ptr_reg,  tag_wr_ptr_next;
  logic [PTR_W-1:0] tag_rd_ptr_reg,  tag_rd_ptr_next;
  logic [PTR_W-1:0] buf_wr_ptr_reg,  buf_wr_ptr_next;
  logic [PTR_W-1:0] buf_rd_ptr_reg,  buf_rd_ptr_next;

  // Storage read views, one element per entry.
  logic [31:0] tag_entries  [DEPTH];
  logic [31:0] data_entries [DEPTH];
  logic [31:0] pc_entries   [DEPTH];

  // Handshake and event decode.
  logic [CREDIT_W-1:0] credit_used;
  logic                req_fire;
  logic                rsp_drop;
  logic                rsp_keep;
  logic                buf_push;
  logic                buf_pop;
  logic                target_misaligned;
  logic [31:0]         rsp_tag;

  assign credit_used = CREDIT_W'(inflight_reg) + CREDIT_W'(occ_reg) + CREDIT_W'(drop_reg);

  // Requests are held off while in reset, after a fault, in a redirect cycle,
  // and whenever every credit is taken.
  assign imem_req_valid = rst_n && !fault_reg && !branch_taken && (credit_used < CREDIT_LIMIT);
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is discarded while pre-redirect requests remain outstanding.
  assign rsp_drop = imem_rsp_valid && (drop_reg != '0);
  assign rsp_keep = imem_rsp_valid && (drop_reg == '0);
  assign rsp_tag  = tag_entries[tag_rd_ptr_reg];

  // A kept response arriving in a redirect cycle is still discarded.
  assign buf_push = rsp_keep && !branch_taken;
  assign buf_pop  = inst_valid && inst_ready;

  assign target_misaligned = branch_taken && (branch_addr[1:0] != 2'b00);

  // Head of the buffer goes to decode; zero when empty so nothing stale shows.
  assign inst_valid  = (occ_reg != '0);
  assign inst_data   = inst_valid ? data_entries[buf_rd_ptr_reg] : 32'h0;
  assign inst_pc     = inst_valid ? pc_entries[buf_rd_ptr_reg]   : 32'h0;
  assign fetch_fault = fault_reg;

  // Next-state computation for PC, counters, pointers and fault flag.
  always_comb begin
    pc_next         = pc_reg;
    inflight_next   = inflight_reg;
    drop_next       = drop_reg;
    occ_next        = occ_reg;
    fault_next      = fault_reg;
    tag_wr_ptr_next = tag_wr_ptr_reg;
    tag_rd_ptr_next = tag_rd_ptr_reg;
    buf_wr_ptr_next = buf_wr_ptr_reg;
    buf_rd_ptr_next = buf_rd_ptr_reg;

    // The tag FIFO mirrors memory traffic exactly: one push per accepted
    // request, one pop per response, whether the response is kept or dropped.
    if (req_fire) begin
      tag_wr_ptr_next = ptr_inc(tag_wr_ptr_reg);
    end
    if (imem_rsp_valid) begin
      tag_rd_ptr_next = ptr_inc(tag_rd_ptr_reg);
    end

    if (branch_taken) begin
      // Redirect: everything in flight becomes a drop. A response that lands
      // this same cycle consumes one of those drops immediately.
      if (target_misaligned) begin
        fault_next = 1'b1;
      end else begin
        pc_next = branch_addr;
      end
      drop_next       = drop_reg + inflight_reg - CNT_W'(imem_rsp_valid);
      inflight_next   = '0;
      occ_next        = '0;
      buf_wr_ptr_next = '0;
      buf_rd_ptr_next = '0;
    end else begin
      if (req_fire) begin
        pc_next = pc_reg + 32'd4;
      end
      if (rsp_drop) begin
        drop_next = drop_reg - CNT_W'(1);
      end
      inflight_next = inflight_reg + CNT_W'(req_fire) - CNT_W'(rsp_keep);
      if (buf_push) begin
        buf_wr_ptr_next = ptr_inc(buf_wr_ptr_reg);
      end
      if (buf_pop) begin
        buf_rd_ptr_next = ptr_inc(buf_rd_ptr_reg);
      end
      occ_next = occ_reg + CNT_W'(buf_push) - CNT_W'(buf_pop);
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      inflight_reg   <= '0;
      drop_reg       <= '0;
      occ_reg        <= '0;
      fault_reg      <= 1'b0;
      tag_wr_ptr_reg <= '0;
      tag_rd_ptr_reg <= '0;
      buf_wr_ptr_reg <= '0;
      buf_rd_ptr_reg <= '0;
    end else begin
      pc_reg         <= pc_next;
      inflight_reg   <= inflight_next;
      drop_reg       <= drop_next;
      occ_reg        <= occ_next;
      fault_reg      <= fault_next;
      tag_wr_ptr_reg <= tag_wr_ptr_next;
      tag_rd_ptr_reg <= tag_rd_ptr_next;
      buf_wr_ptr_reg <= buf_wr_ptr_next;
      buf_rd_ptr_reg <= buf_rd_ptr_next;
    end
  end

  // Per-entry storage. Contents need no reset: occupancy and pointers decide
  // what is valid, and the outputs are gated to zero when the buffer is empty.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [31:0] tag_reg;
    logic [31:0] data_reg;
    logic [31:0] pc_reg_e;

    // Capture the PC of each accepted request in its tag slot.
    always_ff @(posedge clk) begin
      if (req_fire && (tag_wr_ptr_reg == PTR_W'(gi))) begin
        tag_reg <= pc_reg;
      end
    end

    // Capture a kept response word together with its tag.
    always_ff @(posedge clk) begin
      if (buf_push && (buf_wr_ptr_reg == PTR_W'(gi))) begin
        data_reg <= imem_rsp_data;
        pc_reg_e <= rsp_tag;
      end
    end

    assign tag_entries[gi]  = tag_reg;
    assign data_entries[gi] = data_reg;
    assign pc_entries[gi]   = pc_reg_e;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with an in-order memory model that answers
// one cycle after acceptance (or holds responses while mem_on is low).
// Instruction word for address A is ~A, so every delivery is self-describing.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          MAXO   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC       (RST_PC),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_taken  (branch_taken),
    .branch_addr   (branch_addr),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .fetch_fault   (fetch_fault)
  );

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  bit          mem_on;
  logic [31:0] mem_q   [$];
  logic [31:0] acc_log [$];
  logic [31:0] got_pc  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction

  // One clock: sample handshakes mid-cycle, then advance the memory model.
  task automatic tick();
    bit          acc;
    bit          rsp_fire;
    logic [31:0] a;
    @(negedge clk);
    acc      = imem_req_valid && imem_req_ready;
    a        = imem_req_addr;
    rsp_fire = imem_rsp_valid;
    if (rst_n) begin
      check("credit_bound", {31'b0, (dut.credit_used <= 5'(MAXO))}, 32'd1);
    end
    if (inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      $display("deliver pc=%h data=%h", inst_pc, inst_data);
      check("inst_data_vs_pc", inst_data, ~inst_pc);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      if (rsp_fire && (mem_q.size() > 0)) void'(mem_q.pop_front());
      if (acc) begin
        mem_q.push_back(a);
        acc_log.push_back(a);
      end
      if (mem_on && (mem_q.size() > 0)) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~mem_q[0];
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    branch_taken   = 1'b0;
    branch_addr    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    mem_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    acc_log.delete();
    got_pc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b1;
    branch_taken   = 1'b0;
    branch_addr    = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b1;
    mem_on         = 1'b1;

    // Asynchronous reset, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);

    // Streaming fetch from RESET_PC.
    do_reset();
    ticks(12);
    check("stream_req0", acc_at(0), 32'h100);
    check("stream_req1", acc_at(1), 32'h104);
    check("stream_req2", acc_at(2), 32'h108);
    check("stream_req3", acc_at(3), 32'h10C);
    check("stream_pc0", got_at(0), 32'h100);
    check("stream_pc1", got_at(1), 32'h104);
    check("stream_pc2", got_at(2), 32'h108);
    check("stream_pc3", got_at(3), 32'h10C);

    // Decode stall: credits cap accepted requests at two.
    do_reset();
    inst_ready = 1'b0;
    ticks(10);
    check("stall_acc_count", acc_log.size(), 32'd2);
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
    check("stall_head_pc", inst_pc, 32'h100);
    check("stall_head_data", inst_data, ~32'h100);
    inst_ready = 1'b1;
    ticks(6);
    check("stall_pc0", got_at(0), 32'h100);
    check("stall_pc1", got_at(1), 32'h104);
    check("stall_req2", acc_at(2), 32'h108);

    // Redirect with two requests in flight: both responses dropped.
    mem_on = 1'b0;
    do_reset();
    ticks(2);
    check("redir_full_credit", {31'b0, imem_req_valid}, 32'd0);
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    mem_on       = 1'b1;
    tick();
    branch_taken = 1'b0;
    got_pc.delete();
    #1;
    check("redir_drops_hold", {31'b0, imem_req_valid}, 32'd0);
    check("redir_inst_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    check("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h200);
    ticks(8);
    check("redir_pc0", got_at(0), 32'h200);
    check("redir_pc1", got_at(1), 32'h204);

    // Redirect coinciding with a pop and a response.
    do_reset();
    ticks(2);
    check("coinc_inst_valid", {31'b0, inst_valid}, 32'd1);
    check("coinc_rsp_valid", {31'b0, imem_rsp_valid}, 32'd1);
    check("coinc_head_pc", inst_pc, 32'h100);
    branch_taken = 1'b1;
    branch_addr  = 32'h300;
    tick();
    branch_taken = 1'b0;
    got_pc.delete();
    #1;
    check("coinc_flushed", {31'b0, inst_valid}, 32'd0);
    check("coinc_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("coinc_req_addr", imem_req_addr, 32'h300);
    ticks(8);
    check("coinc_pc0", got_at(0), 32'h300);
    check("coinc_pc1", got_at(1), 32'h304);

    // Misaligned target: sticky fault, drops drain, reset recovers.
    mem_on = 1'b0;
    do_reset();
    ticks(2);
    branch_taken = 1'b1;
    branch_addr  = 32'h202;
    mem_on       = 1'b1;
    tick();
    branch_taken = 1'b0;
    #1;
    check("fault_set", {31'b0, fetch_fault}, 32'd1);
    check("fault_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("fault_inst_valid", {31'b0, inst_valid}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("fault_hold_req", {31'b0, imem_req_valid}, 32'd0);
      check("fault_hold_inst", {31'b0, inst_valid}, 32'd0);
    end
    check("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    check("fault_drained", mem_q.size(), 32'd0);
    check("fault_no_deliv", got_pc.size(), 32'd0);
    rst_n = 1'b0;
    #1;
    check("fault_cleared", {31'b0, fetch_fault}, 32'd0);
    check("fault_rst_addr", imem_req_addr, RST_PC);
    check("fault_rst_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    acc_log.delete();
    got_pc.delete();
    ticks(6);
    check("fault_restart_pc", got_at(0), 32'h100);

    // PC wraps from the top of the address space.
    imem_req_ready = 1'b0;
    mem_on         = 1'b0;
    do_reset();
    #1;
    check("wrap_wait_valid", {31'b0, imem_req_valid}, 32'd1);
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    #1;
    check("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_top_valid", {31'b0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    tick();
    check("wrap_next_addr", imem_req_addr, 32'h0000_0000);
    check("wrap_acc0", acc_at(0), 32'hFFFF_FFFC);
    mem_on = 1'b1;
    ticks(8);
    check("wrap_pc0", got_at(0), 32'hFFFF_FFFC);
    check("wrap_pc1", got_at(1), 32'h0000_0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
